tx_comma_serializer: RTL and testbench

Transmit-side counterpart of the receive comma detector and deserializer. Accepts pre-encoded 10-bit symbols over a ready/valid handshake and shifts them out one bit per clk, LSB first. Inserts K28.5 commas of the correct running disparity so the far-end receiver can acquire and keep 10-bit alignment:
- an initial sync burst;
- periodic insertion every COMMA_INTERVAL data symbols;
- filler whenever no data is offered.

Also handles electrical idle and lane polarity inversion.

---
 rtl/tx_comma_serializer.sv | 154 +++++++++++++++
 tb/tb_tx_comma_serializer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tx_comma_serializer.sv
// Serial transmitter for pre-encoded 10-bit symbols, LSB first.
// Inserts RD-correct K28.5 commas for sync bursts, periodic alignment and filler.
module tx_comma_serializer #(
   parameter int              DATA_WIDTH     = 10,
   parameter logic [DATA_WIDTH-1:0] COMMA_RD_NEG = 10'h0FA,
   parameter logic [DATA_WIDTH-1:0] COMMA_RD_POS = 10'h305,
   parameter int              INIT_COMMAS    = 4,
   parameter int              COMMA_INTERVAL = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] TxData,
   input  logic                  TxDataValid,
   input  logic                  TxPolarity,
   input  logic                  TxElecIdle,
   output logic                  TxReady,
   output logic                  Ser_out,
   output logic                  Comma_Sent,
   output logic                  Symbol_Start,
   output logic                  Disp_Err
);

   localparam int SW = $clog2(INIT_COMMAS + 1);
   localparam int IW = $clog2(COMMA_INTERVAL + 1);
   localparam logic [SW-1:0] SYNC_LAST = SW'(INIT_COMMAS);
   localparam logic [IW-1:0] INT_MAX   = IW'(COMMA_INTERVAL);
   localparam logic [3:0]    BIT_LAST  = 4'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      DATA
   } state_t;

   state_t                state, state_n;
   logic [3:0]            bit_cnt, bit_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic                  rd, rd_n;
   logic [SW-1:0]         sync_cnt, sync_n;
   logic [IW-1:0]         int_cnt, int_n;
   logic                  cs_n, ss_n, de_n;

   logic                  load, load_data, data_slot;
   logic [DATA_WIDTH-1:0] comma, load_val;
   logic [3:0]            n_ones;

   function automatic logic [3:0] ones(input logic [DATA_WIDTH-1:0] v);
      logic [3:0] c;
      c = '0;
      for (int i = 0; i < DATA_WIDTH; i++)
         c = c + {3'b000, v[i]};
      return c;
   endfunction

   assign comma     = rd ? COMMA_RD_POS : COMMA_RD_NEG;
   assign data_slot = (state == DATA) ||
                      ((state == SYNC) && (sync_cnt == SYNC_LAST));
   assign load_val  = load_data ? TxData : comma;
   assign n_ones    = ones(load_val);

   assign TxReady = rst_n && (state != IDLE) && (bit_cnt == BIT_LAST) &&
                    data_slot && (int_cnt < INT_MAX) && !TxElecIdle;
   assign Ser_out = (state == IDLE) ? 1'b0 : (shreg[0] ^ TxPolarity);

   always_comb begin
      state_n   = state;
      bit_n     = bit_cnt;
      shreg_n   = shreg;
      sync_n    = sync_cnt;
      int_n     = int_cnt;
      load      = 1'b0;
      load_data = 1'b0;
      unique case (state)
         IDLE: begin
            if (!TxElecIdle) begin
               load    = 1'b1;
               state_n = SYNC;
               sync_n  = SW'(1);
               int_n   = '0;
               bit_n   = '0;
            end
         end
         SYNC, DATA: begin
            if (bit_cnt != BIT_LAST) begin
               shreg_n = {1'b0, shreg[DATA_WIDTH-1:1]};
               bit_n   = bit_cnt + 4'd1;
            end else begin
               bit_n = '0;
               if (!data_slot) begin
                  load   = 1'b1;
                  sync_n = sync_cnt + 1'b1;
               end else if (TxElecIdle) begin
                  state_n = IDLE;
               end else begin
                  state_n = DATA;
                  load    = 1'b1;
                  if (int_cnt == INT_MAX) begin
                     int_n = '0;
                  end else if (TxDataValid) begin
                     load_data = 1'b1;
                     int_n     = int_cnt + 1'b1;
                  end else begin
                     int_n = '0;
                  end
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (load)
         shreg_n = load_val;
   end

   // Running disparity follows the ones count; off-balance data leaves it alone.
   always_comb begin
      rd_n = rd;
      de_n = 1'b0;
      ss_n = load;
      cs_n = load && !load_data;
      if (load) begin
         if (n_ones == 4'd6)
            rd_n = 1'b1;
         else if (n_ones == 4'd4)
            rd_n = 1'b0;
         else if (n_ones != 4'd5)
            de_n = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         rd           <= 1'b0;
         sync_cnt     <= '0;
         int_cnt      <= '0;
         Comma_Sent   <= 1'b0;
         Symbol_Start <= 1'b0;
         Disp_Err     <= 1'b0;
      end else begin
         state        <= state_n;
         bit_cnt      <= bit_n;
         shreg        <= shreg_n;
         rd           <= rd_n;
         sync_cnt     <= sync_n;
         int_cnt      <= int_n;
         Comma_Sent   <= cs_n;
         Symbol_Start <= ss_n;
         Disp_Err     <= de_n;
      end
   end

endmodule

// File: tb/tb_tx_comma_serializer.sv
// Directed bench for tx_comma_serializer: sync burst, interval commas,
// filler disparity, polarity, electrical idle and mid-symbol reset.
module tb_tx_comma_serializer;

   logic       clk;
   logic       rst_n;
   logic [9:0] TxData;
   logic       TxDataValid;
   logic       TxPolarity;
   logic       TxElecIdle;
   logic       TxReady;
   logic       Ser_out;
   logic       Comma_Sent;
   logic       Symbol_Start;
   logic       Disp_Err;

   int n_chk  = 0;
   int n_fail = 0;

   tx_comma_serializer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .TxData       (TxData),
      .TxDataValid  (TxDataValid),
      .TxPolarity   (TxPolarity),
      .TxElecIdle   (TxElecIdle),
      .TxReady      (TxReady),
      .Ser_out      (Ser_out),
      .Comma_Sent   (Comma_Sent),
      .Symbol_Start (Symbol_Start),
      .Disp_Err     (Disp_Err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called in the bit0 cycle of a symbol; returns in its bit9 cycle.
   task automatic expect_sym(input string tag, input logic [9:0] sym,
                             input logic comma, input logic rdy,
                             input logic de);
      logic [9:0] s;
      logic       cs, ss, d, p1;
      cs   = Comma_Sent;
      ss   = Symbol_Start;
      d    = Disp_Err;
      s[0] = Ser_out;
      p1   = 1'b0;
      for (int i = 1; i < 10; i++) begin
         tick();
         s[i] = Ser_out;
         if (i == 1)
            p1 = Comma_Sent | Symbol_Start | Disp_Err;
      end
      chk({tag, "_sym"},   32'(s),       32'(sym));
      chk({tag, "_comma"}, 32'(cs),      32'(comma));
      chk({tag, "_start"}, 32'(ss),      32'd1);
      chk({tag, "_derr"},  32'(d),       32'(de));
      chk({tag, "_pulse"}, 32'(p1),      32'd0);
      chk({tag, "_rdy"},   32'(TxReady), 32'(rdy));
   endtask

   initial begin
      logic [9:0] s;
      rst_n       = 1'b0;
      TxData      = '0;
      TxDataValid = 1'b0;
      TxPolarity  = 1'b0;
      TxElecIdle  = 1'b0;
      tick();
      tick();
      chk("rst_ser",   32'(Ser_out),      32'd0);
      chk("rst_rdy",   32'(TxReady),      32'd0);
      chk("rst_comma", 32'(Comma_Sent),   32'd0);
      chk("rst_start", 32'(Symbol_Start), 32'd0);
      chk("rst_derr",  32'(Disp_Err),     32'd0);

      rst_n = 1'b1;
      tick();
      expect_sym("burst0", 10'h0FA, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("burst1", 10'h305, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("burst2", 10'h0FA, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("burst3", 10'h305, 1'b1, 1'b1, 1'b0); tick();
      expect_sym("fill0",  10'h0FA, 1'b1, 1'b1, 1'b0); tick();
      expect_sym("fill1",  10'h305, 1'b1, 1'b1, 1'b0);

      TxDataValid = 1'b1;
      TxData      = 10'h2AA;
      tick();
      for (int k = 0; k < 16; k++) begin
         expect_sym($sformatf("d2AA_%0d", k), 10'h2AA, 1'b0,
                    (k < 15) ? 1'b1 : 1'b0, 1'b0);
         tick();
      end
      expect_sym("forced", 10'h0FA, 1'b1, 1'b1, 1'b0);
      TxDataValid = 1'b0;
      tick();
      expect_sym("fill2", 10'h305, 1'b1, 1'b1, 1'b0);

      TxDataValid = 1'b1;
      TxData      = 10'h0F8;
      tick();
      expect_sym("d0F8", 10'h0F8, 1'b0, 1'b1, 1'b0);
      TxData = 10'h3E0;
      tick();
      expect_sym("d3E0", 10'h3E0, 1'b0, 1'b1, 1'b0);
      TxDataValid = 1'b0;
      tick();
      expect_sym("fillA", 10'h0FA, 1'b1, 1'b1, 1'b0); tick();
      expect_sym("fillB", 10'h305, 1'b1, 1'b1, 1'b0);
      TxDataValid = 1'b1;
      TxData      = 10'h0FC;
      tick();
      expect_sym("d0FC", 10'h0FC, 0, 1'b1, 1'b0);
      TxDataValid = 1'b0;
      tick();
      expect_sym("fillC", 10'h305, 1'b1, 1'b1, 1'b0);
      tick();

      // Electrical idle requested at bit_cnt==3 of a 0FA filler.
      s[0] = Ser_out;
      for (int i = 1; i < 10; i++) begin
         tick();
         if (i == 3)
            TxElecIdle = 1'b1;
         s[i] = Ser_out;
      end
      chk("eidle_sym", 32'(s),       32'h0FA);
      chk("eidle_rdy", 32'(TxReady), 32'd0);
      tick();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("idle_ser%0d", k),   32'(Ser_out),      32'd0);
         chk($sformatf("idle_rdy%0d", k),   32'(TxReady),      32'd0);
         chk($sformatf("idle_start%0d", k), 32'(Symbol_Start), 32'd0);
         tick();
      end
      TxElecIdle = 1'b0;
      tick();
      expect_sym("wake0", 10'h305, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("wake1", 10'h0FA, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("wake2", 10'h305, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("wake3", 10'h0FA, 1'b1, 1'b1, 1'b0); tick();

      // Reset at bit_cnt==5 of the following filler.
      for (int i = 0; i < 5; i++)
         tick();
      rst_n = 1'b0;
      tick();
      chk("mrst_ser",   32'(Ser_out),      32'd0);
      chk("mrst_rdy",   32'(TxReady),      32'd0);
      chk("mrst_comma", 32'(Comma_Sent),   32'd0);
      chk("mrst_start", 32'(Symbol_Start), 32'd0);
      chk("mrst_derr",  32'(Disp_Err),     32'd0);
      rst_n = 1'b1;
      tick();
      expect_sym("rb0", 10'h0FA, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("rb1", 10'h305, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("rb2", 10'h0FA, 1'b1, 1'b0, 1'b0); tick();
      expect_sym("rb3", 10'h305, 1'b1, 1'b1, 1'b0);
      TxDataValid = 1'b1;
      TxData      = 10'h3FF;
      tick();
      expect_sym("d3FF", 10'h3FF, 1'b0, 1'b1, 1'b1);
      TxDataValid = 1'b0;
      tick();
      expect_sym("fillD", 10'h0FA, 1'b1, 1'b1, 1'b0);

      // Inverted line during the sync burst, then a mid-symbol toggle.
      rst_n = 1'b0;
      tick();
      rst_n      = 1'b1;
      TxPolarity = 1'b1;
      tick();
      expect_sym("pol0", 10'h305, 1'b1, 1'b0, 1'b0);
      tick();
      chk("pol_inv", 32'(Ser_out), 32'd0);
      TxPolarity = 1'b0;
      #1;
      chk("pol_tog", 32'(Ser_out), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
